// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - two-requester round-robin APB master with ACCESS-phase watchdog
// Grants one local command at a time, runs SETUP/ACCESS, and returns rdata/err to the winner.
module apb_master_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            pclk,
    input  logic            presetn,
    input  logic [1:0]      req_valid,
    input  logic [1:0]      req_write,
    input  logic [2*AW-1:0] req_addr,
    input  logic [2*DW-1:0] req_wdata,
    output logic [1:0]      req_accept,
    output logic [1:0]      rsp_valid,
    output logic [DW-1:0]   rsp_rdata,
    output logic            rsp_err,
    output logic            rsp_timeout,
    output logic            psel,
    output logic            penable,
    output logic            pwrite,
    output logic [AW-1:0]   paddr,
    output logic [DW-1:0]   pwdata,
    input  logic [DW-1:0]   prdata,
    input  logic            pready,
    input  logic            pslverr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t     state;
    logic       rr_ptr;
    logic       owner;
    logic [7:0] wdog;
    logic       win;

    // rr_ptr only breaks ties; a lone requester always wins.
    always_comb begin
        win = (req_valid == 2'b11) ? rr_ptr : req_valid[1];
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state       <= IDLE;
            rr_ptr      <= 1'b0;
            owner       <= 1'b0;
            wdog        <= '0;
            req_accept  <= '0;
            rsp_valid   <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
        end else begin
            req_accept  <= '0;
            rsp_valid   <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    if (|req_valid) begin
                        req_accept <= win ? 2'b10 : 2'b01;
                        owner      <= win;
                        rr_ptr     <= ~win;
                        pwrite     <= req_write[win];
                        paddr      <= win ? req_addr[2*AW-1:AW]  : req_addr[AW-1:0];
                        pwdata     <= win ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
                        psel       <= 1'b1;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    wdog    <= '0;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        rsp_valid <= owner ? 2'b10 : 2'b01;
                        rsp_err   <= pslverr;
                        rsp_rdata <= (!pwrite && !pslverr) ? prdata : '0;
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        state     <= IDLE;
                    end else if (wdog == 8'(TIMEOUT - 1)) begin
                        rsp_valid   <= owner ? 2'b10 : 2'b01;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        wdog <= wdog + 8'd1;
                    end
                end
                default: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb/tb_apb_master_arbiter.sv - scoreboard bench for apb_master_arbiter with a 32-word register-file slave
module tb_apb_master_arbiter;

    logic        pclk;
    logic        presetn;
    logic [1:0]  req_valid;
    logic [1:0]  req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  req_accept;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    apb_master_arbiter #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
        .pclk(pclk), .presetn(presetn),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_accept(req_accept), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Register-file slave: one wait state, so pready lands on the second ACCESS cycle.
    logic [31:0] mem [0:31];
    logic        slv_rdy;
    logic        stall;

    always @(posedge pclk) begin
        if (!presetn) begin
            slv_rdy <= 1'b0;
            for (int i = 0; i < 32; i++) mem[i] <= 32'h1000_0000 + i;
        end else begin
            slv_rdy <= psel && penable && !slv_rdy && !stall;
            if (psel && penable && slv_rdy && pwrite && paddr < 32) mem[paddr[4:0]] <= pwdata;
        end
    end

    assign pready  = slv_rdy;
    assign pslverr = slv_rdy && (paddr >= 32);
    assign prdata  = (slv_rdy && paddr < 32) ? mem[paddr[4:0]] : 32'h0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
        int          lat;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    int   acc_log[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   lat = 0;
    logic setup_seen = 1'b0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge pclk) begin
        if (!presetn) begin
            setup_seen = 1'b0;
        end else begin
            exp_t e;
            if (req_accept != 2'b00) begin
                acc_log.push_back(int'(req_accept[1]));
                lat = 1;
            end else begin
                lat++;
            end
            if (psel && !penable) setup_seen = 1'b1;
            if (psel && penable) check("apb_seq", setup_seen, 1);
            if (!psel) setup_seen = 1'b0;
            if (rsp_valid == 2'b00) begin
                check("rsp_idle", {rsp_rdata, rsp_err, rsp_timeout}, 0);
            end else begin
                check("rsp_onehot", (rsp_valid == 2'b01) || (rsp_valid == 2'b10), 1);
                if (rsp_valid[1] ? (sb1.size() == 0) : (sb0.size() == 0)) begin
                    check("rsp_unexpected", rsp_valid, 0);
                end else begin
                    e = rsp_valid[1] ? sb1.pop_front() : sb0.pop_front();
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_err", rsp_err, e.err);
                    check("rsp_timeout", rsp_timeout, e.to);
                    check("latency", lat, e.lat);
                end
            end
        end
    end

    task automatic issue(input int r, input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] exp_rd, input logic exp_err, input logic exp_to, input int exp_lat);
        exp_t e;
        logic got;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.to    = exp_to;
        e.lat   = exp_lat;
        if (r == 0) sb0.push_back(e);
        else        sb1.push_back(e);
        req_write[r]          = wr;
        req_addr[r*32 +: 32]  = addr;
        req_wdata[r*32 +: 32] = data;
        req_valid[r]          = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge pclk);
            if (req_accept[r]) got = 1'b1;
        end
        req_valid[r] = 1'b0;
        check("accept_seen", got, 1);
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge pclk);
            if (sb0.size() == 0 && sb1.size() == 0 && !psel) done = 1'b1;
        end
        check("idle_wait", done, 1);
    endtask

    task automatic do_reset();
        presetn = 1'b0;
        repeat (2) @(negedge pclk);
        presetn = 1'b1;
    endtask

    function automatic logic [127:0] all_outs();
        return {req_accept, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
                psel, penable, pwrite, paddr, pwdata};
    endfunction

    initial begin
        logic found;
        presetn   = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        stall     = 1'b0;
        repeat (3) @(negedge pclk);
        check("reset_outs", all_outs(), 0);
        presetn = 1'b1;
        @(negedge pclk);

        // write then read back through req0
        issue(0, 1'b1, 32'd5, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, 4);
        wait_idle();
        issue(0, 1'b0, 32'd5, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 4);
        wait_idle();

        // both requesters continuously valid from reset: strict alternation
        do_reset();
        acc_log.delete();
        fork
            begin
                issue(0, 1'b0, 32'd1, 32'h0, 32'h1000_0001, 1'b0, 1'b0, 4);
                issue(0, 1'b0, 32'd1, 32'h0, 32'h1000_0001, 1'b0, 1'b0, 4);
            end
            begin
                issue(1, 1'b0, 32'd2, 32'h0, 32'h1000_0002, 1'b0, 1'b0, 4);
                issue(1, 1'b0, 32'd2, 32'h0, 32'h1000_0002, 1'b0, 1'b0, 4);
            end
        join
        wait_idle();
        check("rr_count", acc_log.size(), 4);
        for (int i = 0; i < 4 && i < acc_log.size(); i++) check("rr_order", acc_log[i], i % 2);

        // out-of-range address -> slave error
        issue(1, 1'b0, 32'd40, 32'h0, 32'h0, 1'b1, 1'b0, 4);
        wait_idle();

        // stalled slave -> watchdog abort after 16 ACCESS cycles, then normal traffic
        stall = 1'b1;
        issue(0, 1'b0, 32'd3, 32'h0, 32'h0, 1'b1, 1'b1, 18);
        wait_idle();
        stall = 1'b0;
        issue(0, 1'b0, 32'd5, 32'h0, 32'h1000_0005, 1'b0, 1'b0, 4);
        wait_idle();

        // req0 pulsed and withdrawn while req1 is on the bus
        acc_log.delete();
        fork
            issue(1, 1'b0, 32'd3, 32'h0, 32'h1000_0003, 1'b0, 1'b0, 4);
            begin
                found = 1'b0;
                for (int i = 0; i < 50 && !found; i++) begin
                    @(negedge pclk);
                    if (psel) found = 1'b1;
                end
                req_valid[0] = 1'b1;
                @(negedge pclk);
                req_valid[0] = 1'b0;
            end
        join
        wait_idle();
        repeat (3) @(negedge pclk);
        check("withdraw_count", acc_log.size(), 1);
        if (acc_log.size() > 0) check("withdraw_who", acc_log[0], 1);

        // reset in the middle of ACCESS
        issue(0, 1'b1, 32'd7, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 4);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (psel && penable) found = 1'b1;
            else @(negedge pclk);
        end
        check("access_reached", found, 1);
        presetn = 1'b0;
        @(negedge pclk);
        check("midreset_outs", all_outs(), 0);
        sb0.delete();
        sb1.delete();
        presetn = 1'b1;
        acc_log.delete();
        fork
            issue(0, 1'b0, 32'd1, 32'h0, 32'h1000_0001, 1'b0, 1'b0, 4);
            issue(1, 1'b0, 32'd2, 32'h0, 32'h1000_0002, 1'b0, 1'b0, 4);
        join
        wait_idle();
        check("post_reset_first", (acc_log.size() > 0) ? acc_log[0] : -1, 0);

        repeat (3) @(negedge pclk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

endmodule
